cs_rr_scheduler: RTL and testbench
==================================

Name: cs_rr_scheduler

Overview:
- Round-robin scheduler that shares the 3-to-8 active-low chip-select decoder among 8 requesters.
- Drives the decoder's sel[2:0] and enb (active-high disable), so at most one decoded select line is low at any time.
- Each grant lasts a bounded time slot, followed by a programmable turnaround gap with all selects deasserted.
- Sits between bus-master request logic and the decoder; the decoder output feeds peripheral chip selects.

Parameters:
- SLOT_W, 4, width of slot_len input and slot counter.
- GAP_CYCLES, 1, idle cycles with enb=1 between consecutive grants; legal range 0..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  8  request vector, bit i = requester i; level, held while access wanted.
- slot_len  input  SLOT_W  max grant length in cycles, sampled at grant start; 0 treated as 1.
- enb  output  1  decoder disable, 1 = all selects high.
- sel  output  3  decoder select = index of granted requester.
- gnt  output  8  one-hot grant, mirrors sel when enb=0, all zero otherwise.
- busy  output  1  1 in GRANT or GAP state.

Behaviour:
- Reset values (asynchronous, while rst=1): enb=1, sel=0, gnt=0, busy=0, state=IDLE, rr pointer=0, counters=0.
- All outputs are registered; there is no combinational path from req to outputs.
- Invariant: enb=0 iff exactly one gnt bit is set, and gnt[sel]=1 in that case.
- States: IDLE, GRANT, GAP.
- IDLE: enb=1, gnt=0, sel holds its last value.
  - If req!=0 at edge t, the winner is the first set bit searching upward from the pointer, wrapping 7->0.
  - At t+1: state=GRANT, sel=winner, gnt=1<<winner, enb=0, slot counter loaded with max(slot_len,1).
  - Latency from a sampled request to grant is 1 cycle.
- GRANT:
  - The counter decrements each cycle.
  - The grant ends at the edge where the counter equals 1, or at the first edge where req[sel]=0 (early release), whichever comes first.
  - At grant end: pointer = sel+1 mod 8 (wraps 7->0), enb=1, gnt=0.
  - If GAP_CYCLES>0, go to GAP with the gap counter loaded with GAP_CYCLES.
  - If GAP_CYCLES=0, arbitrate in the same edge: a winner goes straight to GRANT; with no requests, go to IDLE. A back-to-back grant to a different requester is allowed, with sel changing and enb staying 0. This is the only no-gap case.
  - A grant to the same requester never re-issues without passing through the pointer advance.
- GAP: enb=1, gnt=0, busy=1. The counter decrements; at the edge where it equals 1, arbitrate exactly as in IDLE.
- Fairness: with all 8 requesting continuously, grant order is 0,1,…,7,0. Worst-case wait per requester is 7·(2^SLOT_W−1+GAP_CYCLES) cycles.
- Requests arriving or dropping during GAP affect only the next arbitration. A requester that drops req before being granted is simply skipped.
- slot_len changes during GRANT are ignored until the next grant.
- rst asserted mid-grant immediately forces enb=1 and gnt=0 (asynchronous); the pointer returns to 0.

Decomposition:
- Shared package cs_sched_pkg holds:
  - state enum (IDLE, GRANT, GAP);
  - NUM_REQ=8 and SEL_W=3 constants;
  - function rr_pick(req, ptr) returning {found, index}.
- One natural sub-module: rr_arb8, a combinational round-robin priority picker (req[7:0], ptr[2:0] -> valid, idx[2:0]), reusable for other shared resources.

Test Plan:
- Reset check: rst=1 mid-grant (sel=3, enb=0) -> enb=1 and gnt=0 immediately, without waiting for a clock edge; after release with req=0, outputs stay enb=1, sel=0, gnt=0, busy=0.
- Single request: req=8'h04 at edge t, slot_len=3, GAP_CYCLES=1 -> enb=0, sel=2, gnt=8'h04 during cycles t+1..t+3, then one gap cycle with enb=1, then a regrant to 2 if still requesting.
- All-request rotation: req=8'hFF held, slot_len=1, GAP_CYCLES=1 -> sel sequence 0,1,2,…,7,0 with one enb=1 cycle between each grant.
- Wrap from top: pointer=7, req=8'h81 -> grant 7 first, then 0; next with req=8'h80 only -> grant 7 again after the gap.
- Early release: req=8'h10, slot_len=10; drop req[4] 2 cycles into the grant -> enb=1 at the next edge, pointer=5.
- GAP_CYCLES=0 variant: req=8'h03 held, slot_len=2 -> sel 0,0,1,1,0,…; enb stays 0 throughout; gnt stays one-hot on every cycle.

Source files
------------

// File: rtl/cs_sched_pkg.sv
// Shared types and helpers for the chip-select round-robin scheduler.
// The rr_pick helper is also used by other shared-resource arbiters.
package cs_sched_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Returns {found, index}. The search starts at ptr and moves upward,
    // wrapping 7->0, so the requester closest above ptr wins.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        // Walk offsets high to low so the smallest offset is written last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arb8.sv
// Combinational 8-way round-robin priority picker.
// The caller owns the pointer; this block only searches from it.
module rr_arb8
    import cs_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [SEL_W-1:0]   idx_o
);

    logic [SEL_W:0] pick;

    always_comb begin
        pick    = rr_pick(req_i, ptr_i);
        valid_o = pick[SEL_W];
        idx_o   = pick[SEL_W-1:0];
    end

endmodule

// File: rtl/cs_rr_scheduler.sv
// Round-robin owner of a 3-to-8 active-low chip-select decoder.
// Each grant is a bounded slot followed by an optional all-deselected gap.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no grant, decoder disabled, waiting for any request
// ST_GRANT | one requester owns the decoder, slot counter running
// ST_GAP   | turnaround, decoder disabled, gap counter running
module cs_rr_scheduler
    import cs_sched_pkg::*;
#(
    parameter int SLOT_W     = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [SLOT_W-1:0]  slot_len,
    output logic               enb,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy
);

    localparam logic [2:0] GAP_LD = 3'(GAP_CYCLES);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                enb_q, enb_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                busy_q, busy_d;
    logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
    logic [2:0]          gap_cnt_q, gap_cnt_d;

    logic [SEL_W-1:0]    arb_ptr;
    logic                arb_valid;
    logic [SEL_W-1:0]    arb_idx;
    logic [SLOT_W-1:0]   slot_ld;
    logic                start_grant;
    logic                grant_end;

    // A grant ending with no gap re-arbitrates from the advanced pointer
    // in the same edge, so the picker sees sel+1 rather than ptr_q.
    always_comb begin
        arb_ptr = ptr_q;
        if (state_q == ST_GRANT) begin
            arb_ptr = sel_q + SEL_W'(1);
        end
    end

    rr_arb8 u_arb (
        .req_i   (req),
        .ptr_i   (arb_ptr),
        .valid_o (arb_valid),
        .idx_o   (arb_idx)
    );

    always_comb begin
        slot_ld = slot_len;
        if (slot_len == '0) begin
            slot_ld = SLOT_W'(1);
        end
    end

    always_comb begin
        grant_end = (slot_cnt_q == SLOT_W'(1)) || !req[sel_q];
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        enb_d       = enb_q;
        gnt_d       = gnt_q;
        slot_cnt_d  = slot_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        start_grant = 1'b0;

        case (state_q)
            ST_IDLE: begin
                enb_d = 1'b1;
                gnt_d = '0;
                if (arb_valid) begin
                    start_grant = 1'b1;
                end
            end

            ST_GRANT: begin
                if (grant_end) begin
                    ptr_d = sel_q + SEL_W'(1);
                    enb_d = 1'b1;
                    gnt_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LD;
                    end else if (arb_valid) begin
                        start_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    slot_cnt_d = slot_cnt_q - SLOT_W'(1);
                end
            end

            ST_GAP: begin
                enb_d = 1'b1;
                gnt_d = '0;
                // <=1 rather than ==1 so a zero count can never stall here.
                if (gap_cnt_q <= 3'd1) begin
                    if (arb_valid) begin
                        start_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 3'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                enb_d   = 1'b1;
                gnt_d   = '0;
            end
        endcase

        if (start_grant) begin
            state_d    = ST_GRANT;
            sel_d      = arb_idx;
            gnt_d      = NUM_REQ'(1) << arb_idx;
            enb_d      = 1'b0;
            slot_cnt_d = slot_ld;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            enb_q      <= 1'b1;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            slot_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            enb_q      <= enb_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            slot_cnt_q <= slot_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign enb  = enb_q;
    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_cs_rr_scheduler.sv
// Directed bench for cs_rr_scheduler: a one-cycle gap instance and a
// zero-gap instance share the same stimulus.
module tb_cs_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [3:0] slot_len = 4'd0;

    logic       enb,  enb0;
    logic [2:0] sel,  sel0;
    logic [7:0] gnt,  gnt0;
    logic       busy, busy0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cs_rr_scheduler #(.SLOT_W(4), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req(req), .slot_len(slot_len),
        .enb(enb), .sel(sel), .gnt(gnt), .busy(busy)
    );

    cs_rr_scheduler #(.SLOT_W(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .slot_len(slot_len),
        .enb(enb0), .sel(sel0), .gnt(gnt0), .busy(busy0)
    );

    typedef struct packed {
        logic [7:0] req;
        logic [3:0] sl;
        logic       enb;
        logic [2:0] sel;
        logic [7:0] gnt;
        logic       busy;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        slot_len = 4'd0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".enb"},  {7'd0, enb},  8'h01);
        chk({name, ".sel"},  {5'd0, sel},  8'h00);
        chk({name, ".gnt"},  gnt,          8'h00);
        chk({name, ".busy"}, {7'd0, busy}, 8'h00);
    endtask

    initial begin
        // single request, regrant, early release, ptr=5 resume, slot_len=0
        vecs[0]  = '{8'h04, 4'd3,  1'b0, 3'd2, 8'h04, 1'b1};
        vecs[1]  = '{8'h04, 4'd3,  1'b0, 3'd2, 8'h04, 1'b1};
        vecs[2]  = '{8'h04, 4'd3,  1'b0, 3'd2, 8'h04, 1'b1};
        vecs[3]  = '{8'h04, 4'd3,  1'b1, 3'd2, 8'h00, 1'b1};
        vecs[4]  = '{8'h04, 4'd3,  1'b0, 3'd2, 8'h04, 1'b1};
        vecs[5]  = '{8'h00, 4'd3,  1'b1, 3'd2, 8'h00, 1'b1};
        vecs[6]  = '{8'h00, 4'd3,  1'b1, 3'd2, 8'h00, 1'b0};
        vecs[7]  = '{8'h00, 4'd3,  1'b1, 3'd2, 8'h00, 1'b0};
        vecs[8]  = '{8'h10, 4'd10, 1'b0, 3'd4, 8'h10, 1'b1};
        vecs[9]  = '{8'h10, 4'd10, 1'b0, 3'd4, 8'h10, 1'b1};
        vecs[10] = '{8'h00, 4'd10, 1'b1, 3'd4, 8'h00, 1'b1};
        vecs[11] = '{8'h00, 4'd10, 1'b1, 3'd4, 8'h00, 1'b0};
        vecs[12] = '{8'h30, 4'd0,  1'b0, 3'd5, 8'h20, 1'b1};
        vecs[13] = '{8'h30, 4'd0,  1'b1, 3'd5, 8'h00, 1'b1};
        vecs[14] = '{8'h30, 4'd0,  1'b0, 3'd4, 8'h10, 1'b1};
        vecs[15] = '{8'h00, 4'd0,  1'b1, 3'd4, 8'h00, 1'b1};
        vecs[16] = '{8'h00, 4'd0,  1'b1, 3'd4, 8'h00, 1'b0};

        do_reset();
        chk_idle("reset");
        chk("reset0.enb", {7'd0, enb0}, 8'h01);
        chk("reset0.gnt", gnt0, 8'h00);

        for (int i = 0; i < 17; i++) begin
            req = vecs[i].req;
            slot_len = vecs[i].sl;
            step();
            chk($sformatf("vec%0d.enb", i),  {7'd0, enb},  {7'd0, vecs[i].enb});
            chk($sformatf("vec%0d.sel", i),  {5'd0, sel},  {5'd0, vecs[i].sel});
            chk($sformatf("vec%0d.gnt", i),  gnt,          vecs[i].gnt);
            chk($sformatf("vec%0d.busy", i), {7'd0, busy}, {7'd0, vecs[i].busy});
        end

        // all requesting: 0..7,0 with one gap cycle between grants
        do_reset();
        req = 8'hFF;
        slot_len = 4'd1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("rot%0d.enb", k), {7'd0, enb}, 8'h00);
            chk($sformatf("rot%0d.sel", k), {5'd0, sel}, 8'(k % 8));
            chk($sformatf("rot%0d.gnt", k), gnt, 8'h01 << (k % 8));
            step();
            chk($sformatf("rotgap%0d.enb", k), {7'd0, enb}, 8'h01);
            chk($sformatf("rotgap%0d.gnt", k), gnt, 8'h00);
            chk($sformatf("rotgap%0d.busy", k), {7'd0, busy}, 8'h01);
        end

        // wrap from the top of the pointer range
        do_reset();
        req = 8'h40;
        slot_len = 4'd1;
        step();
        chk("wrap.g6", {5'd0, sel}, 8'd6);
        step();
        req = 8'h81;
        step();
        chk("wrap.g7.sel", {5'd0, sel}, 8'd7);
        chk("wrap.g7.gnt", gnt, 8'h80);
        step();
        chk("wrap.gap.enb", {7'd0, enb}, 8'h01);
        step();
        chk("wrap.g0.sel", {5'd0, sel}, 8'd0);
        chk("wrap.g0.gnt", gnt, 8'h01);
        req = 8'h80;
        step();
        chk("wrap.gap2.enb", {7'd0, enb}, 8'h01);
        step();
        chk("wrap.g7b.sel", {5'd0, sel}, 8'd7);
        chk("wrap.g7b.enb", {7'd0, enb}, 8'h00);

        // zero-gap instance: back-to-back grants, enb stays low
        do_reset();
        req = 8'h03;
        slot_len = 4'd2;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("nogap%0d.enb", i), {7'd0, enb0}, 8'h00);
            chk($sformatf("nogap%0d.sel", i), {5'd0, sel0}, 8'((i >> 1) & 1));
            chk($sformatf("nogap%0d.gnt", i), gnt0, 8'h01 << ((i >> 1) & 1));
            chk($sformatf("nogap%0d.busy", i), {7'd0, busy0}, 8'h01);
        end

        // asynchronous reset in the middle of a grant to requester 3
        do_reset();
        req = 8'h08;
        slot_len = 4'd5;
        step();
        chk("arst.pre.sel", {5'd0, sel}, 8'd3);
        chk("arst.pre.enb", {7'd0, enb}, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.now.enb", {7'd0, enb}, 8'h01);
        chk("arst.now.gnt", gnt, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        req = 8'h00;
        step();
        step();
        chk_idle("arst.after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
